pixel_mux: RTL and testbench

PIXEL_MUX -- requirements
Module: pixel_mux

---
 rtl/pixel_mux_if.sv | 30 +++
 rtl/pixel_mux.sv | 98 +++++++++
 tb/tb_pixel_mux.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_mux_if.sv
// Pixel-pipeline bundle between the PPU fetch/render logic and the palette mux.
interface pixel_mux_if;
  logic        line_start;
  logic        pix_en;
  logic [3:0]  bg_pix;
  logic [3:0]  spr_pix;
  logic        spr_behind;
  logic        spr_zero;
  logic        show_bg;
  logic        show_spr;
  logic        left_bg;
  logic        left_spr;
  logic [13:0] vaddr;
  logic        frame_clr;
  logic [4:0]  pal_addr;
  logic        pix_valid;
  logic        spr0_hit;

  modport master (
    output line_start, pix_en, bg_pix, spr_pix, spr_behind, spr_zero,
           show_bg, show_spr, left_bg, left_spr, vaddr, frame_clr,
    input  pal_addr, pix_valid, spr0_hit
  );

  modport slave (
    input  line_start, pix_en, bg_pix, spr_pix, spr_behind, spr_zero,
           show_bg, show_spr, left_bg, left_spr, vaddr, frame_clr,
    output pal_addr, pix_valid, spr0_hit
  );
endinterface

// File: rtl/pixel_mux.sv
// Background/sprite priority mux producing the palette RAM address, sprite-0 hit and a
// pix_valid strobe delayed VLD_DELAY cycles; all outputs registered, no backpressure.
module pixel_mux #(
  parameter int VLD_DELAY = 2
) (
  input logic        clk,
  input logic        rst,
  pixel_mux_if.slave bus
);

  localparam logic [8:0] X_END = 9'd256;
  localparam logic [8:0] X_LAST = 9'd255;

  logic [8:0]           x;
  logic [4:0]           pal_addr_q;
  logic [VLD_DELAY-1:0] vld_sr;
  logic                 spr0_hit_q;

  logic       accept;
  logic       left_zone;
  logic       bg_opq;
  logic       spr_opq;
  logic       backdrop;
  logic       hit_set;
  logic [4:0] mux_addr;

  // Leftmost 8 pixels are x=0..7; x[8:3] is zero only there.
  assign left_zone = (x[8:3] == 6'd0);
  assign accept    = bus.pix_en && !x[8];

  assign bg_opq  = (bus.bg_pix[1:0] != 2'd0) && bus.show_bg &&
                   (!left_zone || bus.left_bg);
  assign spr_opq = (bus.spr_pix[1:0] != 2'd0) && bus.show_spr &&
                   (!left_zone || bus.left_spr);

  // With rendering off and v pointing into palette space, the PPU shows that entry.
  assign backdrop = !bus.show_bg && !bus.show_spr && (bus.vaddr[13:8] == 6'h3F);

  assign hit_set = accept && bus.spr_zero && bg_opq && spr_opq && (x != X_LAST);

  always_comb begin
    mux_addr = 5'h00;
    if (bg_opq && spr_opq) begin
      mux_addr = bus.spr_behind ? {1'b0, bus.bg_pix} : {1'b1, bus.spr_pix};
    end else if (spr_opq) begin
      mux_addr = {1'b1, bus.spr_pix};
    end else if (bg_opq) begin
      mux_addr = {1'b0, bus.bg_pix};
    end
  end

  // Counter parks at 256 so stray pix_en beyond the visible line is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= X_END;
    end else if (bus.line_start) begin
      x <= 9'd0;
    end else if (bus.pix_en && !x[8]) begin
      x <= x + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pal_addr_q <= 5'h00;
    end else if (backdrop) begin
      pal_addr_q <= bus.vaddr[4:0];
    end else if (accept) begin
      pal_addr_q <= mux_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= accept;
      for (int i = 1; i < VLD_DELAY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spr0_hit_q <= 1'b0;
    end else if (bus.frame_clr) begin
      spr0_hit_q <= 1'b0;
    end else if (hit_set) begin
      spr0_hit_q <= 1'b1;
    end
  end

  assign bus.pal_addr  = pal_addr_q;
  assign bus.pix_valid = vld_sr[VLD_DELAY-1];
  assign bus.spr0_hit  = spr0_hit_q;

endmodule

// File: tb/tb_pixel_mux.sv
// Directed bench for pixel_mux: priority, left clipping, sprite-0 hit, backdrop, counter end, reset.
module tb_pixel_mux;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   pulses;

  pixel_mux_if bus ();

  pixel_mux #(.VLD_DELAY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.line_start = 1'b0;
    bus.pix_en     = 1'b0;
    bus.frame_clr  = 1'b0;
    bus.spr_zero   = 1'b0;
  endtask

  // Pushes n accepted pixels with no sprite-0 involvement.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pix_en   = 1'b1;
      bus.spr_zero = 1'b0;
      tick();
    end
    bus.pix_en = 1'b0;
  endtask

  task automatic line();
    idle();
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle();
    bus.bg_pix     = 4'h0;
    bus.spr_pix    = 4'h0;
    bus.spr_behind = 1'b0;
    bus.show_bg    = 1'b1;
    bus.show_spr   = 1'b1;
    bus.left_bg    = 1'b1;
    bus.left_spr   = 1'b1;
    bus.vaddr      = 14'h0000;
    #12;
    chk("rst_pal", bus.pal_addr, 5'h00);
    chk("rst_vld", bus.pix_valid, 0);
    chk("rst_hit", bus.spr0_hit, 0);
    tick();
    rst = 1'b1;
    tick();

    // Without a line_start the counter sits at 256: nothing accepted.
    bus.pix_en = 1'b1; bus.bg_pix = 4'h6; bus.spr_pix = 4'h9;
    tick(); tick();
    chk("no_line_pal", bus.pal_addr, 5'h00);
    chk("no_line_vld", bus.pix_valid, 0);

    line();
    bus.pix_en = 1'b1; bus.bg_pix = 4'h6; bus.spr_pix = 4'h9; bus.spr_behind = 1'b0;
    tick();
    bus.pix_en = 1'b0;
    chk("spr_front_pal", bus.pal_addr, 5'h19);
    chk("vld_d1", bus.pix_valid, 0);
    tick();
    chk("vld_d2", bus.pix_valid, 1);
    tick();
    chk("vld_d3", bus.pix_valid, 0);

    bus.pix_en = 1'b1; bus.spr_behind = 1'b1;
    tick();
    chk("spr_behind_pal", bus.pal_addr, 5'h06);
    bus.bg_pix = 4'h4; bus.spr_pix = 4'h0;
    tick();
    chk("both_clear_pal", bus.pal_addr, 5'h00);

    // x=3: background clipped in the left strip, sprite not.
    bus.left_bg = 1'b0; bus.left_spr = 1'b1; bus.spr_behind = 1'b0;
    bus.bg_pix = 4'h7; bus.spr_pix = 4'h5; bus.spr_zero = 1'b1;
    tick();
    chk("clip_pal", bus.pal_addr, 5'h15);
    chk("clip_hit", bus.spr0_hit, 0);
    adv(4);
    bus.pix_en = 1'b1; bus.spr_zero = 1'b1;
    tick();
    bus.pix_en = 1'b0; bus.spr_zero = 1'b0;
    chk("x8_pal", bus.pal_addr, 5'h15);
    chk("x8_hit", bus.spr0_hit, 1);
    bus.frame_clr = 1'b1;
    tick();
    bus.frame_clr = 1'b0;
    chk("frame_clr", bus.spr0_hit, 0);

    line();
    adv(255);
    bus.pix_en = 1'b1; bus.spr_zero = 1'b1; bus.spr_behind = 1'b1;
    tick();
    idle();
    chk("x255_pal", bus.pal_addr, 5'h07);
    chk("x255_hit", bus.spr0_hit, 0);

    line();
    adv(100);
    bus.pix_en = 1'b1; bus.spr_zero = 1'b1;
    tick();
    chk("x100_hit_behind", bus.spr0_hit, 1);
    bus.frame_clr = 1'b1;
    tick();
    idle();
    chk("clr_wins", bus.spr0_hit, 0);
    tick();
    chk("clr_sticky", bus.spr0_hit, 0);

    // Rendering off: backdrop address follows v when it points into palette space.
    bus.show_bg = 1'b0; bus.show_spr = 1'b0; bus.vaddr = 14'h3F0D;
    tick();
    chk("backdrop", bus.pal_addr, 5'h0D);
    line();
    bus.vaddr = 14'h2000; bus.bg_pix = 4'h7; bus.spr_pix = 4'h5;
    bus.pix_en = 1'b1;
    tick();
    bus.pix_en = 1'b0;
    chk("off_pal", bus.pal_addr, 5'h00);

    bus.show_bg = 1'b1; bus.show_spr = 1'b1; bus.left_bg = 1'b1;
    bus.vaddr = 14'h0000; bus.bg_pix = 4'h6; bus.spr_pix = 4'h0;
    for (int i = 0; i < 4; i++) tick();
    line();
    pulses = 0;
    for (int i = 0; i < 257; i++) begin
      bus.pix_en = 1'b1;
      bus.bg_pix = (i == 256) ? 4'h5 : 4'h6;
      tick();
      if (bus.pix_valid) pulses++;
    end
    bus.pix_en = 1'b0;
    chk("x256_hold", bus.pal_addr, 5'h06);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.pix_valid) pulses++;
    end
    chk("line_pulses", pulses, 256);

    line();
    bus.pix_en = 1'b1; bus.bg_pix = 4'h7; bus.spr_pix = 4'h9;
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_pal", bus.pal_addr, 5'h00);
    chk("arst_vld", bus.pix_valid, 0);
    tick(); tick();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.pix_valid) pulses++;
    end
    bus.pix_en = 1'b0;
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_pal", bus.pal_addr, 5'h00);
    chk("post_rst_hit", bus.spr0_hit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
